cmd_decoder: RTL and testbench



---
 rtl/cmd_decoder_pkg.sv | 26 ++
 rtl/cmd_decoder_if.sv | 30 +++
 rtl/cmd_dec_buf.sv | 26 ++
 rtl/cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_cmd_decoder.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: shared constants and types for the command decoder.
//   PREFIX  - start-of-packet byte (8'hAA)
//   LEN_W   - width of LEN, CRC and buffer pointers (8)
//   state_t - decoder FSM state encoding
//   crc_add - 8-bit wrapping add used by the additive CRC
package cmd_decoder_pkg;

  localparam int LEN_W = 8;
  localparam logic [7:0] PREFIX = 8'hAA;

  typedef enum logic [2:0] {
    S_HUNT,
    S_GET_DST,
    S_GET_LEN,
    S_GET_DATA,
    S_GET_CRC,
    S_CHECK,     // one-cycle exit of GET_CRC: status pulse, first buffer read
    S_DRAIN
  } state_t;

  function automatic logic [LEN_W-1:0] crc_add(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: byte-in / payload-out signal bundle of the command decoder.
// Handshakes (both sides): a beat transfers on a rising clk edge where valid
// and ready are both high; valid, once raised, holds its data until transfer.
//   rx_data/rx_valid/rx_ready   - receive byte stream (decoder is sink)
//   dst_data/dst_valid/dst_ready - payload to destination FIFOs; dst_valid is
//                                  one-hot over N_DST ports, dst_data shared
//   pkt_ok/err_crc/err_dst/err_tmo - one-cycle status pulses
// N_DST must match the N_DST of the decoder the bundle is connected to.
interface cmd_decoder_if #(parameter int N_DST = 53);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       dst_data;
  logic [N_DST-1:0] dst_valid;
  logic [N_DST-1:0] dst_ready;
  logic             pkt_ok;
  logic             err_crc;
  logic             err_dst;
  logic             err_tmo;

  modport master (
    output rx_data, rx_valid, dst_ready,
    input  rx_ready, dst_data, dst_valid, pkt_ok, err_crc, err_dst, err_tmo
  );

  modport slave (
    input  rx_data, rx_valid, dst_ready,
    output rx_ready, dst_data, dst_valid, pkt_ok, err_crc, err_dst, err_tmo
  );
endinterface

// File: rtl/cmd_dec_buf.sv
// cmd_dec_buf: 256x8 simple dual-port payload buffer, one write port and one
// read port with a registered (1-cycle) read. rdata holds its value while
// re is low, which the drain logic relies on to ride out dst stalls.
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr/rdata - read port, rdata valid the cycle after re
module cmd_dec_buf
  import cmd_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LEN_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [LEN_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:(1<<LEN_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cmd_decoder.sv
// cmd_decoder: parses PREFIX, DEST, LEN, DATA x LEN, CRC from the receive
// byte stream, buffers the payload, checks the 8-bit additive CRC
// (DEST + LEN + sum(DATA) mod 256) and drains good payloads to dst port DEST.
// Bad-CRC and out-of-range-DEST packets are dropped whole.
// Parameters: N_DST (destination count), TIMEOUT_CYC (inter-byte timeout).
// Ports: clk, rst (async, active high), bus (cmd_decoder_if.slave),
//        dbg_state (current FSM state).
// Optional feature: define CMD_DEC_TIMEOUT_EN to enable the inter-byte
// timeout counter and err_tmo; otherwise err_tmo is tied low.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int N_DST       = 53,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic           clk,
  input  logic           rst,
  cmd_decoder_if.slave   bus,
  output state_t         dbg_state
);

  state_t           state, state_nxt;
  logic [7:0]       dest;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] crc;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] tx_cnt;
  logic             dst_bad;
  logic             crc_ok;

  logic             rx_acc;
  logic             xfer;
  logic [N_DST-1:0] dst_valid_c;
  logic             buf_we, buf_re;
  logic [LEN_W-1:0] buf_raddr;
  logic [7:0]       buf_rdata;
  logic             pkt_ok_c, err_crc_c, err_dst_c;
  logic             tmo_hit;

  assign rx_acc = bus.rx_valid & bus.rx_ready;

  cmd_dec_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (bus.rx_data),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

`ifdef CMD_DEC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_pkt;

  assign in_pkt  = (state == S_GET_DST) || (state == S_GET_LEN) ||
                   (state == S_GET_DATA) || (state == S_GET_CRC);
  // A byte arriving in the same cycle wins over the timeout.
  assign tmo_hit = in_pkt && !rx_acc && (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  tmo_cnt <= '0;
    else if (!in_pkt || rx_acc)               tmo_cnt <= '0;
    else if (tmo_cnt != TMO_W'(TIMEOUT_CYC))  tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  wire unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign tmo_hit = 1'b0;
`endif

  // Only DEST's bit can be high; DEST < N_DST is guaranteed in DRAIN.
  always_comb begin
    dst_valid_c = '0;
    for (int i = 0; i < N_DST; i++)
      dst_valid_c[i] = (state == S_DRAIN) && (32'(dest) == i);
  end
  assign xfer = |(dst_valid_c & bus.dst_ready);

  always_comb begin
    state_nxt = state;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    buf_raddr = tx_cnt + 8'd1;   // prefetch the word after the one on dst_data
    pkt_ok_c  = 1'b0;
    err_crc_c = 1'b0;
    err_dst_c = 1'b0;
    case (state)
      S_HUNT:     if (rx_acc && bus.rx_data == PREFIX) state_nxt = S_GET_DST;
      S_GET_DST:  if (rx_acc) state_nxt = S_GET_LEN;
      S_GET_LEN:  if (rx_acc) state_nxt = (bus.rx_data == 8'd0) ? S_GET_CRC : S_GET_DATA;
      S_GET_DATA: if (rx_acc) begin
        buf_we = 1'b1;
        if (wr_ptr == len - 8'd1) state_nxt = S_GET_CRC;
      end
      S_GET_CRC:  if (rx_acc) state_nxt = S_CHECK;
      S_CHECK: begin
        buf_re    = 1'b1;
        buf_raddr = '0;
        if (dst_bad) begin
          err_dst_c = 1'b1;
          state_nxt = S_HUNT;
        end else if (!crc_ok) begin
          err_crc_c = 1'b1;
          state_nxt = S_HUNT;
        end else begin
          pkt_ok_c  = 1'b1;
          state_nxt = (len == 8'd0) ? S_HUNT : S_DRAIN;
        end
      end
      S_DRAIN: if (xfer) begin
        buf_re = 1'b1;
        if (tx_cnt == len - 8'd1) state_nxt = S_HUNT;
      end
      default: state_nxt = S_HUNT;
    endcase
    if (tmo_hit) state_nxt = S_HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HUNT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest    <= '0;
      len     <= '0;
      crc     <= '0;
      wr_ptr  <= '0;
      tx_cnt  <= '0;
      dst_bad <= 1'b0;
      crc_ok  <= 1'b0;
    end else begin
      case (state)
        S_GET_DST: if (rx_acc) begin
          dest    <= bus.rx_data;
          dst_bad <= (32'(bus.rx_data) >= N_DST);
        end
        S_GET_LEN: if (rx_acc) begin
          len    <= bus.rx_data;
          crc    <= crc_add(dest, bus.rx_data);
          wr_ptr <= '0;
        end
        S_GET_DATA: if (rx_acc) begin
          wr_ptr <= wr_ptr + 8'd1;
          crc    <= crc_add(crc, bus.rx_data);
        end
        S_GET_CRC: if (rx_acc) crc_ok <= (bus.rx_data == crc);
        S_CHECK:   tx_cnt <= '0;
        S_DRAIN:   if (xfer) tx_cnt <= tx_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = ~rst & (state != S_DRAIN) & (state != S_CHECK);
  assign bus.dst_valid = dst_valid_c;
  assign bus.dst_data  = (state == S_DRAIN) ? buf_rdata : 8'd0;
  assign bus.pkt_ok    = pkt_ok_c;
  assign bus.err_crc   = err_crc_c;
  assign bus.err_dst   = err_dst_c;
  assign bus.err_tmo   = tmo_hit;
  assign dbg_state     = state;

endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: self-checking bench for cmd_decoder. A packet-level model
// predicts each packet's status and delivered payload; a per-cycle monitor
// checks DUT outputs against it.
module tb_cmd_decoder;
  import cmd_decoder_pkg::*;

  localparam int N_DST = 53;
  localparam int TMO   = 40;
  localparam logic [7:0] ST_OK = 8'd0, ST_CRC = 8'd1, ST_DST = 8'd2, ST_TMO = 8'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_decoder_if #(.N_DST(N_DST)) bus ();
  state_t dbg_state;

  cmd_decoder #(.N_DST(N_DST), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];     // {dest, data} in delivery order
  logic [7:0]  exp_st_q[$];  // status codes in order
  int          log_cyc[$];
  logic [7:0]  log_data[$];
  int          last_ok_cyc = -1;
  int          last_acc_cyc = 0;
  logic [7:0]  pkt_data [0:255];
  int          rdy_mode = 0;  // 0 all ready, 1 random, 2 none ready

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [7:0] model_crc(input logic [7:0] dest, input int len);
    int s;
    s = int'(dest) + len;
    for (int i = 0; i < len; i++) s += int'(pkt_data[i]);
    return 8'(s % 256);
  endfunction

  // ---------------- destination ready driver ----------------
  initial begin
    bus.dst_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.dst_ready = '1;
        1:       bus.dst_ready = N_DST'({$urandom(), $urandom()});
        default: bus.dst_ready = '0;
      endcase
    end
  end

  // ---------------- per-cycle monitor ----------------
  logic [63:0] prev_vd;
  logic        prev_held = 1'b0;
  always @(negedge clk) begin
    int   npulse, idx;
    logic [7:0] code;
    logic       x;
    if (rst) begin
      prev_held = 1'b0;
    end else begin
      npulse = int'(bus.pkt_ok) + int'(bus.err_crc) + int'(bus.err_dst) + int'(bus.err_tmo);
      if (npulse > 1) chk("single_pulse", 64'(npulse), 64'd1);
      else if (npulse == 1) begin
        code = bus.pkt_ok ? ST_OK : bus.err_crc ? ST_CRC : bus.err_dst ? ST_DST : ST_TMO;
        if (bus.pkt_ok) last_ok_cyc = cyc;
        if (exp_st_q.size() == 0) chk("unexpected_status", 64'(code), 64'hff);
        else chk("status", 64'(code), 64'(exp_st_q.pop_front()));
      end
      if (prev_held) chk("valid_hold", {3'b0, bus.dst_valid, bus.dst_data}, prev_vd);
      prev_held = 1'b0;
      if (bus.dst_valid != '0) begin
        chk("rx_ready_in_drain", 64'(bus.rx_ready), 64'd0);
        chk("dst_onehot", 64'($countones(bus.dst_valid)), 64'd1);
        x = |(bus.dst_valid & bus.dst_ready);
        if (x) begin
          idx = -1;
          for (int i = N_DST - 1; i >= 0; i--) if (bus.dst_valid[i]) idx = i;
          if (exp_q.size() == 0) chk("unexpected_drain", {48'd0, 8'(idx), bus.dst_data}, 64'hffff_ffff);
          else chk("drain_byte", {48'd0, 8'(idx), bus.dst_data}, 64'(exp_q.pop_front()));
          log_cyc.push_back(cyc);
          log_data.push_back(bus.dst_data);
        end else begin
          prev_held = 1'b1;
          prev_vd   = {3'b0, bus.dst_valid, bus.dst_data};
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.rx_ready) chk("rx_ready_wait", 64'd0, 64'd1);
    else last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // crc_delta = 0 sends the correct CRC, otherwise CRC + crc_delta.
  task automatic send_pkt(input logic [7:0] dest, input int len, input logic [7:0] crc_delta);
    logic [7:0] crc;
    crc = model_crc(dest, len);
    if (dest >= N_DST)        exp_st_q.push_back(ST_DST);
    else if (crc_delta != 0)  exp_st_q.push_back(ST_CRC);
    else begin
      exp_st_q.push_back(ST_OK);
      for (int i = 0; i < len; i++) exp_q.push_back({dest, pkt_data[i]});
    end
    send_byte(PREFIX);
    send_byte(dest);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pkt_data[i]);
    send_byte(crc + crc_delta);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp_st_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk(name, 64'(exp_q.size() + exp_st_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data(input int len);
    for (int i = 0; i < len; i++) pkt_data[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int crc_acc;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;

    #1;
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_dst_valid", 64'(bus.dst_valid), 64'd0);
    chk("rst_dst_data", 64'(bus.dst_data), 64'd0);
    chk("rst_pulses", {60'd0, bus.pkt_ok, bus.err_crc, bus.err_dst, bus.err_tmo}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_HUNT));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_rst", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1;

    // Good packet AA 02 03 10 20 30 65, with timing pinned by literals.
    pkt_data[0] = 8'h10; pkt_data[1] = 8'h20; pkt_data[2] = 8'h30;
    chk("model_crc_pkt1", 64'(model_crc(8'd2, 3)), 64'h65);
    log_cyc.delete();
    log_data.delete();
    send_pkt(8'd2, 3, 8'd0);
    crc_acc = last_acc_cyc;
    wait_idle("good_pkt");
    chk("p1_count", 64'(log_data.size()), 64'd3);
    if (log_data.size() == 3) begin
      chk("p1_b0", 64'(log_data[0]), 64'h10);
      chk("p1_b1", 64'(log_data[1]), 64'h20);
      chk("p1_b2", 64'(log_data[2]), 64'h30);
      chk("p1_ok_cycle", 64'(last_ok_cyc), 64'(crc_acc + 1));
      chk("p1_first_valid", 64'(log_cyc[0]), 64'(crc_acc + 2));
      chk("p1_back_to_back", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
    end

    // Bad CRC (66), then a good packet.
    send_pkt(8'd2, 3, 8'd1);
    rand_data(5);
    send_pkt(8'd11, 5, 8'd0);
    wait_idle("bad_crc_then_good");

    // Bad destination with correct CRC.
    pkt_data[0] = 8'h55;
    send_pkt(8'(N_DST), 1, 8'd0);
    wait_idle("bad_dst");

    // LEN = 0: AA 05 00 05.
    chk("model_crc_len0", 64'(model_crc(8'd5, 0)), 64'h05);
    send_pkt(8'd5, 0, 8'd0);
    wait_idle("len0");

    // LEN = 255 with data 00..FE under random backpressure.
    for (int i = 0; i < 255; i++) pkt_data[i] = 8'(i);
    chk("model_crc_len255", 64'(model_crc(8'd2, 255)), 64'h82);
    rdy_mode = 1;
    log_data.delete();
    send_pkt(8'd2, 255, 8'd0);
    wait_idle("len255");
    chk("len255_count", 64'(log_data.size()), 64'd255);

    // Backpressure on a medium packet.
    rand_data(40);
    send_pkt(8'd2, 40, 8'd0);
    wait_idle("backpressure");
    rdy_mode = 0;

    // Garbage before PREFIX.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    rand_data(4);
    send_pkt(8'd9, 4, 8'd0);
    wait_idle("garbage");

    // Random packets, back to back, with random garbage between.
    for (int p = 0; p < 40; p++) begin
      logic [7:0] g;
      rdy_mode = $urandom_range(0, 1);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom_range(0, 255));
        if (g == PREFIX) g = 8'h00;
        send_byte(g);
      end
      begin
        int len;
        len = $urandom_range(0, 12);
        rand_data(len);
        send_pkt(8'($urandom_range(0, N_DST + 3)), len,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      end
    end
    rdy_mode = 0;
    wait_idle("random_pkts");

`ifdef CMD_DEC_TIMEOUT_EN
    // Stall after LEN: expect err_tmo, then normal decoding.
    exp_st_q.push_back(ST_TMO);
    send_byte(PREFIX);
    send_byte(8'd1);
    send_byte(8'd2);
    wait_idle("timeout");
    rand_data(3);
    send_pkt(8'd1, 3, 8'd0);
    wait_idle("after_timeout");
`endif

    // Reset in the middle of a stalled drain.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    rand_data(10);
    send_pkt(8'd7, 10, 8'd0);
    begin
      int w;
      w = 0;
      while (bus.dst_valid == '0 && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    chk("stalled_valid", 64'(bus.dst_valid[7]), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_dst_valid", 64'(bus.dst_valid), 64'd0);
    chk("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("mid_rst_dst_data", 64'(bus.dst_data), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("rx_ready_after_mid_rst", 64'(bus.rx_ready), 64'd1);
    chk("state_after_mid_rst", 64'(dbg_state), 64'(S_HUNT));
    @(posedge clk);
    #1;
    rand_data(6);
    send_pkt(8'd52, 6, 8'd0);
    wait_idle("after_mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
